// File: rtl/lut4_rv32_seq_if.sv
// Operand/result handshake bundle for the lut4 sequencer.
// master drives operands and out_ready; slave returns result, in_ready and busy.
interface lut4_rv32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        busy;

    modport master (
        output in_valid, rs1, rs2, out_ready,
        input  in_ready, out_valid, rd, busy
    );

    modport slave (
        input  in_valid, rs1, rs2, out_ready,
        output in_ready, out_valid, rd, busy
    );
endinterface

// File: rtl/lut4_rv32_seq.sv
// Multi-cycle RV32 lut4: rd.4[i] = {2'b00, rs2.2[rs1.4[i]]}, NIB_PER_CYC nibbles per cycle.
// Latency: accept in cycle 0 -> out_valid in cycle 8/NIB_PER_CYC + 1.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module lut4_rv32_seq #(
    parameter int NIB_PER_CYC = 2,
    parameter int XLEN        = 32
) (
    input logic             g_clk,
    input logic             g_reset,
    input logic             flush,
    lut4_rv32_seq_if.slave  io
);

    localparam int GROUPS = 8 / NIB_PER_CYC;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (!(NIB_PER_CYC == 1 || NIB_PER_CYC == 2 || NIB_PER_CYC == 4 || NIB_PER_CYC == 8)) begin : g_bad_nib
        $error("lut4_rv32_seq: NIB_PER_CYC must be 1, 2, 4 or 8");
    end
    if (XLEN != 32) begin : g_bad_xlen
        $error("lut4_rv32_seq: XLEN must be 32");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [31:0]      rd_q;
    logic [31:0]      rd_nxt;
    logic [2:0]       nib;
    logic [3:0]       idx;
    logic             accept;
    logic             last;

    assign io.in_ready  = (state == IDLE) && !g_reset && !flush;
    assign io.out_valid = (state == DONE);
    assign io.busy      = (state != IDLE);
    assign io.rd        = rd_q;

    assign accept = io.in_valid && io.in_ready;
    assign last   = (cnt == CNT_W'(GROUPS - 1));

    always_ff @(posedge g_clk) begin
        if (g_reset || flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = BUSY;
            BUSY:    if (last)         state_nxt = DONE;
            DONE:    if (io.out_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // One shared slice: the current group of nibbles is looked up and merged into rd.
    always_comb begin
        rd_nxt = rd_q;
        nib    = '0;
        idx    = '0;
        for (int g = 0; g < NIB_PER_CYC; g++) begin
            nib = 3'(int'(cnt) * NIB_PER_CYC + g);
            idx = rs1_q[{nib, 2'b00} +: 4];
            rd_nxt[{nib, 2'b00} +: 4] = {2'b00, rs2_q[{idx, 1'b0} +: 2]};
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            cnt   <= '0;
        end else if (flush) begin
            rd_q <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rs1_q <= io.rs1;
                        rs2_q <= io.rs2;
                        rd_q  <= '0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    rd_q <= rd_nxt;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lut4_rv32_seq.sv
// Drives four sequencers (NIB_PER_CYC = 1, 2, 4, 8) in lockstep from one stimulus stream
// and checks them against an arithmetic lut4 model with a per-cycle timing model.
module tb_lut4_rv32_seq;

    logic        g_clk     = 1'b0;
    logic        g_reset   = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] rs1       = '0;
    logic [31:0] rs2       = '0;

    logic [3:0]  ovld;
    logic [3:0]  irdy;
    logic [3:0]  bsy;
    logic [31:0] rdv [4];

    int ntot  = 0;
    int npass = 0;

    always #5 g_clk = ~g_clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        lut4_rv32_seq_if ifc ();
        assign ifc.in_valid  = in_valid;
        assign ifc.rs1       = rs1;
        assign ifc.rs2       = rs2;
        assign ifc.out_ready = out_ready;
        assign ovld[k]       = ifc.out_valid;
        assign irdy[k]       = ifc.in_ready;
        assign bsy[k]        = ifc.busy;
        assign rdv[k]        = ifc.rd;

        lut4_rv32_seq #(.NIB_PER_CYC(1 << k), .XLEN(32)) dut (
            .g_clk   (g_clk),
            .g_reset (g_reset),
            .flush   (flush),
            .io      (ifc)
        );
    end

    function automatic logic [31:0] lut_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int          i_idx;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            i_idx = int'((a >> (4 * i)) & 32'hF);
            r     = r | (((b >> (2 * i_idx)) & 32'h3) << (4 * i));
        end
        return r;
    endfunction

    function automatic logic [31:0] low_mask(input int nibs);
        logic [63:0] m;
        m = (64'd1 << (4 * nibs)) - 64'd1;
        return m[31:0];
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s dut%0d: observed %h, expected %h", tag, k, obs, exp);
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Cycle 0 is the accept cycle. ready_from: first cycle in which out_ready is high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int ready_from,
                          input logic [31:0] junk_a, input logic [31:0] junk_b);
        logic [31:0] exp;
        int          hmax;
        int          da;
        int          h;
        exp  = lut_ref(a, b);
        hmax = 0;
        for (int k = 0; k < 4; k++) begin
            da   = (8 >> k) + 1;
            h    = (da > ready_from) ? da : ready_from;
            hmax = (h > hmax) ? h : hmax;
        end
        rs1       = a;
        rs2       = b;
        in_valid  = 1'b1;
        out_ready = (ready_from <= 0);
        #1;
        for (int k = 0; k < 4; k++) check("in_ready_at_accept", k, 32'(irdy[k]), 32'd1);
        tick();
        in_valid = 1'b0;
        rs1      = junk_a;
        rs2      = junk_b;
        for (int t = 1; t <= hmax + 1; t++) begin
            out_ready = (t >= ready_from);
            #1;
            for (int k = 0; k < 4; k++) begin
                da = (8 >> k) + 1;
                h  = (da > ready_from) ? da : ready_from;
                check("out_valid", k, 32'(ovld[k]), 32'(t >= da && t <= h));
                check("busy", k, 32'(bsy[k]), 32'(t <= h));
                check("in_ready", k, 32'(irdy[k]), 32'(t > h));
                if (t < da)
                    check("rd_partial", k, rdv[k], exp & low_mask((t - 1) * (1 << k)));
                else if (t <= h)
                    check("rd_result", k, rdv[k], exp);
            end
            if (t <= hmax) tick();
        end
    endtask

    initial begin
        // Reset
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            check("rst_out_valid", k, 32'(ovld[k]), 32'd0);
            check("rst_rd", k, rdv[k], 32'd0);
            check("rst_busy", k, 32'(bsy[k]), 32'd0);
            check("rst_in_ready", k, 32'(irdy[k]), 32'd0);
        end
        g_reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check("post_rst_in_ready", k, 32'(irdy[k]), 32'd1);

        // Directed scenarios
        run_op(32'h76543210, 32'hE4E4E4E4, 0, 32'h0, 32'h0);
        run_op(32'h9ABCDEF0, 32'hFFFFFFFF, 11, 32'h0, 32'h0);
        run_op(32'hF0F0F0F0, 32'hC0000003, 0, 32'h0, 32'h0);
        run_op(32'h11111111, 32'hC0000003, 0, 32'h0, 32'h0);
        run_op(32'h76543210, 32'hE4E4E4E4, 0, 32'hFFFFFFFF, 32'h0);

        // Flush in the second BUSY cycle
        rs1       = 32'h76543210;
        rs2       = 32'hE4E4E4E4;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) check("flush_in_ready", k, 32'(irdy[k]), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("flush_out_valid", k, 32'(ovld[k]), 32'd0);
            check("flush_busy", k, 32'(bsy[k]), 32'd0);
            check("flush_rd", k, rdv[k], 32'd0);
            check("flush_in_ready_after", k, 32'(irdy[k]), 32'd1);
        end

        // Flush together with in_valid must not accept
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) check("flush_valid_in_ready", k, 32'(irdy[k]), 32'd0);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check("flush_valid_no_accept", k, 32'(bsy[k]), 32'd0);

        // Reset while the NIB_PER_CYC=2 instance sits in DONE
        rs1       = 32'h76543210;
        rs2       = 32'hE4E4E4E4;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("done_before_rst_vld", 1, 32'(ovld[1]), 32'd1);
        check("done_before_rst_rd", 1, rdv[1], 32'h32103210);
        g_reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) check("midrst_in_ready", k, 32'(irdy[k]), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("midrst_out_valid", k, 32'(ovld[k]), 32'd0);
            check("midrst_rd", k, rdv[k], 32'd0);
            check("midrst_busy", k, 32'(bsy[k]), 32'd0);
            check("midrst_in_ready_held", k, 32'(irdy[k]), 32'd0);
        end
        tick();
        g_reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check("midrst_in_ready_release", k, 32'(irdy[k]), 32'd1);

        run_op(32'h76543210, 32'hE4E4E4E4, 0, 32'h0, 32'h0);

        // Randomized operations with random backpressure and operand scrambling
        for (int n = 0; n < 24; n++) begin
            run_op($urandom, $urandom, int'($urandom_range(0, 12)), $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/lut4_rv32_seq.md
Name: lut4_rv32_seq

Overview:
- Multi-cycle sequencer for the RV32 lut4 operation: for i in 0..7, rd.4[i] = {2'b00, rs2.2[rs1.4[i]]}.
- Processes NIB_PER_CYC nibbles per cycle through one shared nibble-lookup slice, trading latency for area in area-constrained crypto cores.
- Sits behind the execute stage, with a valid/ready handshake on both the operand side and the result side, plus a synchronous flush.

Parameters:
- NIB_PER_CYC, 2, nibbles looked up per BUSY cycle. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
- XLEN, 32, operand width. Fixed at 32; any other value is an elaboration error.

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of any in-flight operation.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- rs1  in  32  eight 4-bit indices.
- rs2  in  32  sixteen 2-bit LUT entries; entry k = rs2[2k+1:2k].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- rd  out  32  result; each nibble = {2'b00, lut entry}.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (g_reset high at an edge):
  - State goes to IDLE; cnt=0; rd=0; out_valid=0; captured operands=0.
  - in_ready is forced low in any cycle where g_reset is high.
- Priority at each edge: g_reset > flush > normal operation.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE) && !g_reset && !flush.
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - On in_valid && in_ready: capture rs1 and rs2 into internal registers, clear the rd register to 0, set cnt=0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle, for g in 0..NIB_PER_CYC-1 with nibble j = cnt*NIB_PER_CYC + g: rd[4j+3:4j] <= {2'b00, rs2_q[2*rs1_q[4j+3:4j] +: 2]}.
  - cnt increments by 1 each cycle.
  - When cnt == 8/NIB_PER_CYC-1, write the final group and go to DONE.
  - cnt width = max(1, clog2(8/NIB_PER_CYC)).
  - Input operand changes during BUSY have no effect; only the captured copies are used.
- DONE:
  - rd and out_valid are held stable until out_ready is high.
  - On out_valid && out_ready: go to IDLE. in_ready rises the next cycle; there is no same-cycle accept in DONE.
- Latency:
  - Accept at the end of cycle 0 gives out_valid in cycle 8/NIB_PER_CYC + 1: cycle 5 for NIB_PER_CYC=2, cycle 9 for 1, cycle 2 for 8.
  - Throughput is one operation per 8/NIB_PER_CYC + 2 cycles when out_ready is held high.
- rd visibility:
  - During BUSY, rd shows partial results: completed groups hold final values, the rest are 0.
  - Consumers must only sample rd when out_valid is high.
- flush:
  - Any state goes to IDLE; out_valid=0; rd=0; cnt=0.
  - flush in the same cycle as in_valid does not accept, because in_ready is low.
  - flush in the same cycle as an out_valid && out_ready handshake means the result is treated as not delivered.
- Reset mid-operation: same effect as flush, and additionally the captured operands are cleared.
- Boundaries:
  - Index 0 selects rs2[1:0]; index 15 selects rs2[31:30].
  - Upper two bits of every rd nibble are always 0.

Test Plan:
- Identity LUT: rs2=0xE4E4E4E4, rs1=0x76543210, NIB_PER_CYC=2, out_ready=1 -> rd=0x32103210, out_valid in cycle 5 after the accept cycle, high for exactly one cycle; in_ready high again in cycle 6.
- Saturating LUT and backpressure: rs2=0xFFFFFFFF, rs1=0x9ABCDEF0, out_ready=0 for 10 cycles then 1 -> rd=0x33333333, held stable with out_valid high throughout; busy stays high until the handshake.
- Top/bottom index: rs2=0xC0000003, rs1=0xF0F0F0F0 -> rd=0x33333333. With the same rs2 and rs1=0x11111111 -> rd=0x00000000.
- Operand isolation: accept rs1=0x76543210 and rs2=0xE4E4E4E4, then drive rs1=0xFFFFFFFF and rs2=0 while BUSY -> rd=0x32103210; in_ready stays low until IDLE.
- Flush and reset mid-op:
  - flush in the 2nd BUSY cycle -> next cycle IDLE, rd=0, out_valid=0.
  - Then g_reset in DONE -> out_valid=0, rd=0, in_ready low while reset is high and high in the cycle after reset drops.
- Parameter sweep: repeat the first scenario for NIB_PER_CYC = 1, 4, 8 -> same rd, out_valid in cycles 9, 3 and 2 respectively.
